// File: rtl/dmem_uart_io.sv
// Data RAM (0x00-0xEF) plus a FIFO-buffered serial debug transmitter at 0xF0/0xF1.
// Optional even-parity bit: define TX_PARITY_EN for 8E1 frames (default 8N1).
module dmem_uart_io #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Address_out,
    input  logic [7:0] Data_out,
    input  logic       MW,
    output logic [7:0] Data_in,
    output logic       tx,
    output logic       tx_busy,
    output logic       ovf
);

    localparam int RAM_SIZE = 240;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W    = $clog2(CLK_DIV);

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       RAM_LAST    = 8'hEF;
    localparam logic [7:0]       ADDR_TXDATA = 8'hF0;
    localparam logic [7:0]       ADDR_STATUS = 8'hF1;

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    logic [7:0]       r_ram  [RAM_SIZE];
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [2:0]       r_bitcnt;
    logic [2:0]       w_bitcnt_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             r_busy;
`ifdef TX_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
`endif

    logic       w_empty;
    logic       w_full;
    logic       w_is_ram;
    logic       w_ram_wr;
    logic       w_txdata_wr;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;
    logic       w_ovf_clr;
    logic       w_bit_end;
    logic [7:0] w_head;

    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_full      = (r_count == CNT_FULL);
    assign w_is_ram    = (Address_out <= RAM_LAST);
    assign w_ram_wr    = MW && w_is_ram;
    assign w_txdata_wr = MW && (Address_out == ADDR_TXDATA);
    // A full FIFO still accepts a byte when the serializer drains one on the same edge.
    assign w_push      = w_txdata_wr && (!w_full || w_pop);
    assign w_drop      = w_txdata_wr && w_full && !w_pop;
    assign w_ovf_clr   = MW && (Address_out == ADDR_STATUS) && Data_out[3];
    assign w_bit_end   = (r_timer == TMR_LAST);
    assign w_head      = r_fifo[r_rptr];

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign ovf     = r_ovf;

    // Load-data mux: RAM, STATUS, or zero for TXDATA and the unmapped range.
    always_comb begin
        Data_in = 8'h00;
        if (w_is_ram) begin
            Data_in = r_ram[Address_out];
        end else if (Address_out == ADDR_STATUS) begin
            Data_in = {4'b0000, r_ovf, r_busy, w_full, w_empty};
        end else begin
            Data_in = 8'h00;
        end
    end

    // Data RAM: synchronous write, whole array cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAM_SIZE; i++) begin
                r_ram[i] <= 8'h00;
            end
        end else if (w_ram_wr) begin
            r_ram[Address_out] <= Data_out;
        end
    end

    // TX FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= 8'h00;
            end
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= Data_out;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serializer next-state logic, including FIFO pop and shift-register reload.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer + TMR_W'(1);
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_pop        = 1'b0;
`ifdef TX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = {TMR_W{1'b0}};
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
`ifdef TX_PARITY_EN
                    w_par_nxt   = even_parity(w_head);
`endif
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_timer_nxt  = {TMR_W{1'b0}};
                    w_bitcnt_nxt = 3'd0;
                    w_state_nxt  = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_timer_nxt  = {TMR_W{1'b0}};
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
`ifdef TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_timer_nxt = {TMR_W{1'b0}};
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next frame so queued bytes leave with no idle gap.
                if (w_bit_end) begin
                    w_timer_nxt = {TMR_W{1'b0}};
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
`ifdef TX_PARITY_EN
                        w_par_nxt   = even_parity(w_head);
`endif
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_timer_nxt = {TMR_W{1'b0}};
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so tx is a clean register output.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef TX_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // Serializer state, timers and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_timer  <= {TMR_W{1'b0}};
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
`ifdef TX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_uart_io.sv
// Directed self-checking bench for dmem_uart_io (RAM map, STATUS, serial frames, FIFO overflow, reset).
module tb_dmem_uart_io;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef TX_PARITY_EN
    localparam int FL = 11 * CLK_DIV;
`else
    localparam int FL = 10 * CLK_DIV;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       mw;
    logic [7:0] rdata;
    logic       tx;
    logic       tx_busy;
    logic       ovf;

    int total;
    int bad;

    dmem_uart_io #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Address_out (addr),
        .Data_out    (wdata),
        .MW          (mw),
        .Data_in     (rdata),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for sample i (0 = first START cycle) of a frame carrying b.
    function automatic logic exp_tx(input logic [7:0] b, input int i);
        int slot;
        slot = i / CLK_DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic drive(input logic m, input logic [7:0] a, input logic [7:0] d);
        mw    = m;
        addr  = a;
        wdata = d;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(1'b0, 8'h10, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_ram got=%h exp=00", rdata); end
        addr = 8'hF1; #1;
        total++; if (rdata !== 8'h01) begin bad++; $display("FAIL reset_status got=%h exp=01", rdata); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_ram;
        @(negedge clk);
        drive(1'b1, 8'h10, 8'h5A); #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL ram_old_on_write got=%h exp=00", rdata); end
        @(negedge clk);
        drive(1'b1, 8'hEF, 8'h3C); #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL ram_ef_before got=%h exp=00", rdata); end
        @(negedge clk);
        drive(1'b1, 8'hF2, 8'h77); #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL unmapped_read got=%h exp=00", rdata); end
        @(negedge clk);
        drive(1'b0, 8'h10, 8'h00); #1;
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL ram_10 got=%h exp=5a", rdata); end
        addr = 8'hEF; #1;
        total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL ram_ef got=%h exp=3c", rdata); end
        addr = 8'hF2; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL write_f2_ignored got=%h exp=00", rdata); end
        addr = 8'hF0; #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL txdata_read got=%h exp=00", rdata); end
        addr = 8'hF1; #1;
        total++; if (rdata !== 8'h01) begin bad++; $display("FAIL status_idle got=%h exp=01", rdata); end
    endtask

    task automatic test_single_frame;
        @(negedge clk);
        drive(1'b1, 8'hF0, 8'hA5);
        @(negedge clk);
        drive(1'b0, 8'hF1, 8'h00); #1;
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL frame_status_queued got=%h exp=00", rdata); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL frame_tx_before_pop got=%b exp=1", tx); end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            total++;
            if (tx !== exp_tx(8'hA5, i)) begin bad++; $display("FAIL frame_a5_tx i=%0d got=%b exp=%b", i, tx, exp_tx(8'hA5, i)); end
            total++;
            if (tx_busy !== 1'b1) begin bad++; $display("FAIL frame_a5_busy i=%0d got=%b exp=1", i, tx_busy); end
        end
        @(negedge clk); #1;
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL frame_busy_end got=%b exp=0", tx_busy); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL frame_tx_end got=%b exp=1", tx); end
        total++; if (rdata !== 8'h01) begin bad++; $display("FAIL frame_status_end got=%h exp=01", rdata); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [6];
        int k;
        int i;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        bytes[3] = 8'h04; bytes[4] = 8'h05; bytes[5] = 8'h09;
        for (int c = 0; c <= 2 + 6 * FL; c++) begin
            @(negedge clk);
            drive(1'b0, 8'hF1, 8'h00);
            if (c <= 5)            drive(1'b1, 8'hF0, 8'(c + 1));
            else if (c == 7)       drive(1'b1, 8'hF1, 8'h08);
            else if (c == 9)       drive(1'b1, 8'hF0, 8'h07);
            else if (c == 10)      drive(1'b1, 8'hF1, 8'h00);
            else if (c == 12)      drive(1'b1, 8'hF1, 8'h08);
            else if (c == FL + 1)  drive(1'b1, 8'hF0, 8'h09);
            #1;
            if (c == 1) begin
                total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_prepop got=%b exp=0", tx_busy); end
            end
            if (c >= 2 && c < 2 + 6 * FL) begin
                k = (c - 2) / FL;
                i = (c - 2) % FL;
                total++;
                if (tx !== exp_tx(bytes[k], i)) begin bad++; $display("FAIL b2b_tx frame=%0d i=%0d got=%b exp=%b", k, i, tx, exp_tx(bytes[k], i)); end
                total++;
                if (tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy frame=%0d i=%0d got=%b exp=1", k, i, tx_busy); end
            end
            if (c == 6) begin
                total++; if (rdata !== 8'h0E) begin bad++; $display("FAIL ovf_status got=%h exp=0e", rdata); end
                total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
            end
            if (c == 8) begin
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
            end
            if (c == 10) begin
                total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_reset_again got=%b exp=1", ovf); end
            end
            if (c == 11) begin
                total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_bit3_zero_keeps got=%b exp=1", ovf); end
            end
            if (c == 13) begin
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear2 got=%b exp=0", ovf); end
            end
            if (c == FL + 2) begin
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b exp=0", ovf); end
                total++; if (rdata !== 8'h06) begin bad++; $display("FAIL full_pushpop_status got=%h exp=06", rdata); end
            end
            if (c == 2 + 6 * FL) begin
                total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
                total++; if (tx !== 1'b1) begin bad++; $display("FAIL b2b_tx_end got=%b exp=1", tx); end
                total++; if (rdata !== 8'h01) begin bad++; $display("FAIL b2b_status_end got=%h exp=01", rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        drive(1'b1, 8'hF0, 8'hC3);
        @(negedge clk);
        drive(1'b0, 8'h10, 8'h00);
        repeat (12) @(negedge clk);
        #1;
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", tx_busy); end
        total++; if (rdata !== 8'h5A) begin bad++; $display("FAIL mid_ram_before got=%h exp=5a", rdata); end
        reset = 1'b0; #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx got=%b exp=1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", tx_busy); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL mid_reset_ram got=%h exp=00", rdata); end
        addr = 8'hF1; #1;
        total++; if (rdata !== 8'h01) begin bad++; $display("FAIL mid_reset_status got=%h exp=01", rdata); end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 8'hF0, 8'h3C);
        @(negedge clk);
        drive(1'b0, 8'hF1, 8'h00);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            total++;
            if (tx !== exp_tx(8'h3C, i)) begin bad++; $display("FAIL post_reset_tx i=%0d got=%b exp=%b", i, tx, exp_tx(8'h3C, i)); end
        end
        @(negedge clk); #1;
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy_end got=%b exp=0", tx_busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ram();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
